// File: rtl/stopwatch_digit_chain_pkg.sv
// Stopwatch digit chain shared types and default digit limits.
// Holds the control FSM encoding and the BCD digit type.
package stopwatch_digit_chain_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } sw_state_t;

  localparam bcd_t DEF_TENTHS_MAX   = 4'd9;
  localparam bcd_t DEF_SEC_TENS_MAX = 4'd5;
  localparam bcd_t DEF_MIN_TENS_MAX = 4'd5;
  localparam bcd_t ONES_MAX         = 4'd9;

endpackage

// File: rtl/stopwatch_digit_chain_bcd_digit_counter.sv
// One BCD digit of the seconds/minutes cascade.
// carry is combinational so a whole chain ripples in one cycle.
module bcd_digit_counter
  import stopwatch_digit_chain_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  input  bcd_t max,
  output bcd_t digit,
  output logic carry
);

  assign carry = inc && (digit >= max);

  // digit register: clear wins, then count with wrap at max
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit <= '0;
    end else if (clr) begin
      digit <= '0;
    end else if (inc) begin
      digit <= carry ? '0 : digit + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_digit_chain.sv
// Stopwatch seconds/minutes cascade, control FSM and display mux.
// Build option: OVERFLOW_STOP_EN holds 59:59 and forces PAUSE on overflow.
module stopwatch_digit_chain
  import stopwatch_digit_chain_pkg::*;
#(
  parameter bcd_t TENTHS_MAX   = DEF_TENTHS_MAX,
  parameter bcd_t SEC_TENS_MAX = DEF_SEC_TENS_MAX,
  parameter bcd_t MIN_TENS_MAX = DEF_MIN_TENS_MAX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] tenths_in,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic       run_en,
  output logic       clear_req,
  output logic [3:0] disp_tenths,
  output logic [3:0] disp_sec_ones,
  output logic [3:0] disp_sec_tens,
  output logic [3:0] disp_min_ones,
  output logic [3:0] disp_min_tens,
  output logic       overflow
);

  sw_state_t state;
  bcd_t      prev_tenths;
  bcd_t      so, st, mo, mt;
  bcd_t      l_t, l_so, l_st, l_mo, l_mt;
  logic      c0, c1, c2, c3;
  logic      counting, wrap_evt;
  logic      inc0, ovf_hit, clr_cnt;
  logic      ss_act, lp_act, cl_act;
  logic      ss_ok;

  // previous tenths value for 9->0 edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_tenths <= '0;
    else       prev_tenths <= tenths_in;
  end

  assign counting = (state == RUN) || (state == LAP);
  assign wrap_evt = counting &&
                    (prev_tenths == TENTHS_MAX) &&
                    (tenths_in == 4'd0);

  assign ss_act = start_stop;
  assign lp_act = lap && !start_stop;
  assign cl_act = clear && !start_stop && !lap;

`ifdef OVERFLOW_STOP_EN
  logic all_max;
  assign all_max = (so == ONES_MAX) &&
                   (st == SEC_TENS_MAX) &&
                   (mo == ONES_MAX) &&
                   (mt == MIN_TENS_MAX);
  assign inc0    = wrap_evt && !all_max;
  assign ovf_hit = (wrap_evt && all_max) || c3;
  assign ss_ok   = !overflow;
`else
  assign inc0    = wrap_evt;
  assign ovf_hit = c3;
  assign ss_ok   = 1'b1;
`endif

  assign clr_cnt = cl_act &&
                   ((state == IDLE) || (state == PAUSE));

  bcd_digit_counter u_sec_ones (
    .clk(clk), .reset(reset), .inc(inc0), .clr(clr_cnt),
    .max(ONES_MAX), .digit(so), .carry(c0)
  );

  bcd_digit_counter u_sec_tens (
    .clk(clk), .reset(reset), .inc(c0), .clr(clr_cnt),
    .max(SEC_TENS_MAX), .digit(st), .carry(c1)
  );

  bcd_digit_counter u_min_ones (
    .clk(clk), .reset(reset), .inc(c1), .clr(clr_cnt),
    .max(ONES_MAX), .digit(mo), .carry(c2)
  );

  bcd_digit_counter u_min_tens (
    .clk(clk), .reset(reset), .inc(c2), .clr(clr_cnt),
    .max(MIN_TENS_MAX), .digit(mt), .carry(c3)
  );

  // control FSM with registered run_en/clear_req/overflow and lap latches
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      run_en    <= 1'b0;
      clear_req <= 1'b0;
      overflow  <= 1'b0;
      l_t       <= '0;
      l_so      <= '0;
      l_st      <= '0;
      l_mo      <= '0;
      l_mt      <= '0;
    end else begin
      clear_req <= 1'b0;
      if (ovf_hit) overflow <= 1'b1;
      unique case (state)
        IDLE: begin
          if (ss_act) begin
            state  <= RUN;
            run_en <= 1'b1;
          end else if (cl_act) begin
            clear_req <= 1'b1;
            overflow  <= 1'b0;
          end
        end
        RUN: begin
          if (ss_act) begin
            state  <= PAUSE;
            run_en <= 1'b0;
          end else if (lp_act) begin
            state <= LAP;
            l_t   <= tenths_in;
            l_so  <= so;
            l_st  <= st;
            l_mo  <= mo;
            l_mt  <= mt;
          end
        end
        LAP: begin
          if (ss_act) begin
            state  <= PAUSE;
            run_en <= 1'b0;
          end else if (lp_act) begin
            state <= RUN;
          end
        end
        PAUSE: begin
          if (ss_act) begin
            if (ss_ok) begin
              state  <= RUN;
              run_en <= 1'b1;
            end
          end else if (cl_act) begin
            state     <= IDLE;
            clear_req <= 1'b1;
            overflow  <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          run_en <= 1'b0;
        end
      endcase
`ifdef OVERFLOW_STOP_EN
      if (wrap_evt && all_max) begin
        state  <= PAUSE;
        run_en <= 1'b0;
      end
`endif
    end
  end

  // display shows frozen lap digits only while in LAP
  always_comb begin
    disp_tenths   = tenths_in;
    disp_sec_ones = so;
    disp_sec_tens = st;
    disp_min_ones = mo;
    disp_min_tens = mt;
    if (state == LAP) begin
      disp_tenths   = l_t;
      disp_sec_ones = l_so;
      disp_sec_tens = l_st;
      disp_min_ones = l_mo;
      disp_min_tens = l_mt;
    end
  end

endmodule

// File: doc/stopwatch_digit_chain.md
Name: stopwatch_digit_chain

Overview:
- Downstream consumer of the 0-9 tenths-of-second digit.
- Detects each tenths wrap (9->0) and cascades BCD seconds and minutes, MM:SS range 00:00-59:59.
- Owns the stopwatch control FSM (start/stop, lap freeze, clear).
- Presents five frozen-or-live BCD digits to the display stage.

Parameters:
- TENTHS_MAX, 9, value of tenths_in immediately before a wrap.
- SEC_TENS_MAX, 5, maximum of the seconds-tens digit.
- MIN_TENS_MAX, 5, maximum of the minutes-tens digit.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tenths_in  in  4  BCD tenths digit from the upstream tenths counter
- start_stop  in  1  one-cycle pulse, already debounced and synchronous
- lap  in  1  one-cycle pulse, already debounced and synchronous
- clear  in  1  one-cycle pulse, already debounced and synchronous
- run_en  out  1  high in RUN/LAP; gates the upstream counter
- clear_req  out  1  one-cycle pulse requesting upstream tenths clear
- disp_tenths  out  4  displayed tenths digit
- disp_sec_ones  out  4  displayed seconds-ones digit
- disp_sec_tens  out  4  displayed seconds-tens digit
- disp_min_ones  out  4  displayed minutes-ones digit
- disp_min_tens  out  4  displayed minutes-tens digit
- overflow  out  1  sticky flag, set on 59:59.9 -> 00:00 wrap

Behaviour:
- Reset: all outputs 0; FSM = IDLE; prev_tenths = 0; internal counts 0; lap latches 0.
- prev_tenths register samples tenths_in every cycle.
- wrap_evt = (prev_tenths == TENTHS_MAX) && (tenths_in == 0) && state in {RUN, LAP}.
  - Counts advance on the cycle after wrap_evt is seen (1-cycle latency).
- Cascade on wrap_evt:
  - sec_ones 0-9, then sec_tens 0-SEC_TENS_MAX, then min_ones 0-9, then min_tens 0-MIN_TENS_MAX.
  - Each digit wraps to 0 and carries into the next.
  - Full wrap of min_tens: all digits become 0 and overflow sets.
  - Digits stay 4-bit BCD; never exceed their max.
- Button priority on the same cycle: start_stop > lap > clear. Lower-priority pulses are dropped.
- FSM transitions:
  - IDLE: start_stop -> RUN. lap ignored. clear -> clears counts, pulses clear_req, stays IDLE.
  - RUN: start_stop -> PAUSE. lap -> LAP (latch all five live digits). clear ignored.
  - LAP: counting continues, display shows latched values. lap -> RUN (live display). start_stop -> PAUSE (display returns to live).
  - PAUSE: start_stop -> RUN. clear -> IDLE, clears counts and overflow, pulses clear_req. lap ignored.
- Display mux: LAP shows latched digits; every other state shows live digits. disp_tenths live = tenths_in.
- Edge cases:
  - Wrap coincident with lap: the latched value is pre-increment; the live count still increments.
  - Wrap coincident with start_stop leaving RUN: the increment is still applied.
  - clear_req is high exactly one cycle. Next-cycle tenths_in = 0 is not a wrap, because it is gated by state.
  - Asynchronous reset mid-count returns everything to reset values immediately.
  - tenths_in > 9 is never a wrap source; it is passed to the display unchanged.

Optional Feature:
- OVERFLOW_STOP_EN defined: at the 59:59.9 wrap, counts hold at 59:59.
  - FSM forces PAUSE; overflow sets.
  - A later start_stop from that PAUSE is refused; only clear leaves it.
- Not defined: counts wrap to 00:00, overflow sets (sticky), counting continues.

Decomposition:
- Shared package holds:
  - FSM state enum IDLE/RUN/LAP/PAUSE (2-bit).
  - BCD digit type (4-bit).
  - Constants TENTHS_MAX, SEC_TENS_MAX, MIN_TENS_MAX defaults.
- One natural sub-module: bcd_digit_counter.
  - Inputs: inc, clr, max value.
  - Outputs: digit, carry.
  - Instantiated four times in the cascade.

Test Plan:
- Reset, start_stop, drive tenths 0..9..0 ten times -> disp_sec_ones = 1, others 0; run_en = 1.
- Preload to 00:59, one wrap -> disp 01:00, sec_tens returns to 0 and min_ones = 1.
- RUN at 00:12, lap, 3 wraps -> display holds 00:12, live = 00:15; lap again -> display 00:15.
- start_stop in RUN, then 5 tenths wraps on tenths_in -> count unchanged; clear -> counts 0, clear_req high one cycle, state IDLE.
- Count at 59:59, wrap -> 00:00 with overflow = 1.
  - With OVERFLOW_STOP_EN: holds 59:59, state PAUSE, start_stop ignored.
- start_stop and clear pulsed on the same cycle in PAUSE -> state RUN, counts retained, no clear_req.
